decode_writeback: RTL

DECODE_WRITEBACK -- requirements
Module: decode_writeback

---
 rtl/decode_writeback.sv | 118 +++++++++++
 1 files changed

// File: rtl/decode_writeback.sv
// rtl/decode_writeback.sv - Y86-64 decode register read and writeback register file
module decode_writeback (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        Cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        wr_en,
  input  logic [3:0]  dbg_sel,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [63:0] dbg_val
);

  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam int         NUM_REGS = 15;

  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  logic [63:0] regs_q [NUM_REGS];
  logic [63:0] regs_d [NUM_REGS];

  logic [3:0] src_a;
  logic [3:0] src_b;
  logic [3:0] dst_e;
  logic [3:0] dst_m;

  // Decode register specifiers from the instruction class; unknown icodes touch nothing.
  always_comb begin
    src_a = REG_NONE;
    src_b = REG_NONE;
    dst_e = REG_NONE;
    dst_m = REG_NONE;
    unique case (icode)
      I_CMOV: begin
        src_a = rA;
        // rrmovq (ifun 0) is an unconditional move even if Cnd were low.
        if (Cnd || (ifun == 4'h0)) dst_e = rB;
      end
      I_IRMOV: dst_e = rB;
      I_RMMOV: begin
        src_a = rA;
        src_b = rB;
      end
      I_MRMOV: begin
        src_b = rB;
        dst_m = rA;
      end
      I_OPQ: begin
        src_a = rA;
        src_b = rB;
        dst_e = rB;
      end
      I_CALL: begin
        src_b = REG_RSP;
        dst_e = REG_RSP;
      end
      I_RET: begin
        src_a = REG_RSP;
        src_b = REG_RSP;
        dst_e = REG_RSP;
      end
      I_PUSH: begin
        src_a = rA;
        src_b = REG_RSP;
        dst_e = REG_RSP;
      end
      I_POP: begin
        src_a = REG_RSP;
        src_b = REG_RSP;
        dst_e = REG_RSP;
        dst_m = rA;
      end
      default: begin
        src_a = REG_NONE;
      end
    endcase
  end

  // Read ports see pre-edge contents only; id 0xF reads as zero.
  always_comb begin
    valA    = (src_a   == REG_NONE) ? 64'd0 : regs_q[src_a];
    valB    = (src_b   == REG_NONE) ? 64'd0 : regs_q[src_b];
    dbg_val = (dbg_sel == REG_NONE) ? 64'd0 : regs_q[dbg_sel];
  end

  // Next register-file contents; the memory port is applied last so popq %rsp keeps valM.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      if (dst_e != REG_NONE) regs_d[dst_e] = valE;
      if (dst_m != REG_NONE) regs_d[dst_m] = valM;
    end
  end

  // Register file state with reset overriding any same-edge write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 64'd0;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule
